// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM states and flag bundle.
package alu_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_MUL = 4'b0010,
      OP_SHL = 4'b0100,
      OP_SHR = 4'b0101,
      OP_ASR = 4'b0110,
      OP_AND = 4'b1000,
      OP_OR  = 4'b1001,
      OP_XOR = 4'b1010,
      OP_NOT = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MUL_RUN = 2'd1,
      ST_HOLD    = 2'd2
   } alu_state_e;

   typedef struct packed {
      logic carry;
      logic zero;
      logic overflow;
      logic sign;
      logic err;
   } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle after i_start.
// o_product_c carries the final product in the cycle o_done_c is high.
module alu_mul_iter #(
   parameter int unsigned MUL_HALF = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic [MUL_HALF-1:0]     i_a,
   input  logic [MUL_HALF-1:0]     i_b,
   output logic                    o_done_c,
   output logic [2*MUL_HALF-1:0]   o_product_c
);

   localparam int unsigned PW = 2 * MUL_HALF;
   localparam int unsigned CW = $clog2(MUL_HALF + 1);

   logic                r_busy;
   logic [CW-1:0]       r_cnt;
   logic [PW-1:0]       r_acc;
   logic [PW-1:0]       r_mcand;
   logic [MUL_HALF-1:0] r_mplier;
   logic [PW-1:0]       w_acc_next;

   assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign o_done_c    = r_busy && (r_cnt == CW'(MUL_HALF - 1));
   assign o_product_c = w_acc_next;

   // Multiplier bits are consumed LSB first while the multiplicand shifts left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= PW'(i_a);
         r_mplier <= i_b;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (o_done_c) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; single-cycle ops plus an iterative MUL,
// all results landing in one registered output bank held until consumed.
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MUL_HALF = WIDTH / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             overflow,
   output logic             sign,
   output logic             err
);

   localparam int unsigned SW  = WIDTH + 1;
   localparam int unsigned MSB = WIDTH - 1;

   alu_state_e          r_state;
   logic [WIDTH-1:0]    r_result;
   alu_flags_t          r_flags;

   logic                w_accept;
   logic                w_is_mul;
   logic                w_mul_done;
   logic                w_load;
   logic [2*MUL_HALF-1:0] w_product;

   logic                w_sub;
   logic [WIDTH-1:0]    w_b_eff;
   logic [WIDTH:0]      w_sum;
   logic                w_add_ovf;

   logic [WIDTH-1:0]    w_res;
   logic                w_carry;
   logic                w_ovf;
   logic                w_err;

   logic [WIDTH-1:0]    w_ld_res;
   alu_flags_t          w_ld_flags;

   assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
   assign out_valid = (r_state == ST_HOLD);
   assign w_accept  = in_valid && in_ready;
   assign w_is_mul  = (op == OP_MUL);
   assign w_load    = (w_accept && !w_is_mul) || ((r_state == ST_MUL_RUN) && w_mul_done);

   alu_mul_iter #(.MUL_HALF(MUL_HALF)) u_mul (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (w_accept && w_is_mul),
      .i_a         (a[MUL_HALF-1:0]),
      .i_b         (b[MUL_HALF-1:0]),
      .o_done_c    (w_mul_done),
      .o_product_c (w_product)
   );

   // SUB reuses the adder as a + ~b + 1, so signed overflow compares against ~b.
   assign w_sub     = (op == OP_SUB);
   assign w_b_eff   = w_sub ? ~b : b;
   assign w_sum     = {1'b0, a} + {1'b0, w_b_eff} + SW'(w_sub);
   assign w_add_ovf = (a[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != a[MSB]);

   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      w_err   = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
            w_ovf   = w_add_ovf;
         end
         OP_MUL: ;
         OP_SHL: begin
            w_res   = {a[WIDTH-2:0], 1'b0};
            w_carry = a[MSB];
         end
         OP_SHR: begin
            w_res   = {1'b0, a[WIDTH-1:1]};
            w_carry = a[0];
         end
         OP_ASR: begin
            w_res   = {a[MSB], a[WIDTH-1:1]};
            w_carry = a[0];
         end
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_NOT:  w_res = ~a;
         default: w_err = 1'b1;
      endcase
   end

   // Output bank source: multiplier product while MUL runs, otherwise the live datapath.
   always_comb begin
      w_ld_res            = w_res;
      w_ld_flags.carry    = w_carry;
      w_ld_flags.overflow = w_ovf;
      w_ld_flags.err      = w_err;
      if (r_state == ST_MUL_RUN) begin
         w_ld_res            = WIDTH'(w_product);
         w_ld_flags.carry    = 1'b0;
         w_ld_flags.overflow = 1'b0;
         w_ld_flags.err      = 1'b0;
      end
      w_ld_flags.zero = (w_ld_res == '0);
      w_ld_flags.sign = w_ld_res[MSB];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_HOLD: begin
               if (w_accept) begin
                  r_state <= w_is_mul ? ST_MUL_RUN : ST_HOLD;
               end else if ((r_state == ST_HOLD) && out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_MUL_RUN: begin
               if (w_mul_done) begin
                  r_state <= ST_HOLD;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_flags  <= '0;
      end else if (w_load) begin
         r_result <= w_ld_res;
         r_flags  <= w_ld_flags;
      end
   end

   assign result   = r_result;
   assign carry    = r_flags.carry;
   assign zero     = r_flags.zero;
   assign overflow = r_flags.overflow;
   assign sign     = r_flags.sign;
   assign err      = r_flags.err;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu (WIDTH = 8) against an arithmetic reference model.
module tb_seq_alu;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [3:0] op = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic       carry, zero, overflow, sign, err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(8), .MUL_HALF(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .overflow  (overflow),
      .sign      (sign),
      .err       (err)
   );

   // Reference: {result, carry, zero, overflow, sign, err} from plain integer arithmetic.
   function automatic logic [12:0] model(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] ya);
      int unsigned x, y, r;
      int          sx, sy;
      logic        c, v, e;
      x  = xa;
      y  = ya;
      sx = (x >= 128) ? int'(x) - 256 : int'(x);
      sy = (y >= 128) ? int'(y) - 256 : int'(y);
      r = 0; c = 1'b0; v = 1'b0; e = 1'b0;
      case (o)
         4'h0: begin r = x + y; c = (r > 255); v = (sx + sy > 127) || (sx + sy < -128); end
         4'h1: begin r = x + (255 - y) + 1; c = (r > 255); v = (sx - sy > 127) || (sx - sy < -128); end
         4'h2: r = (x % 16) * (y % 16);
         4'h4: begin r = x * 2; c = (x >= 128); end
         4'h5: begin r = x / 2; c = ((x % 2) == 1); end
         4'h6: begin r = x / 2 + ((x >= 128) ? 128 : 0); c = ((x % 2) == 1); end
         4'h8: r = x & y;
         4'h9: r = x | y;
         4'hA: r = x ^ y;
         4'hC: r = 255 - x;
         default: e = 1'b1;
      endcase
      r = r % 256;
      return {8'(r), c, (r == 0), v, (r >= 128), e};
   endfunction

   // Issue one command with out_ready high; returns the observed outputs and latency in edges.
   task automatic run_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] ya,
                         output logic [12:0] obs, output int lat);
      int guard;
      @(negedge clk);
      in_valid = 1'b1; op = o; a = xa; b = ya; out_ready = 1'b1;
      #1;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk); #1; guard++;
      end
      @(negedge clk);
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk); lat++;
      end
      obs = {result, carry, zero, overflow, sign, err};
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({out_valid, result, carry, zero, overflow, sign, err} !== 14'h0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0", {out_valid, result, carry, zero, overflow, sign, err});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      logic [12:0] obs;
      int          lat;
      logic [3:0]  ops [4] = '{4'h0, 4'h1, 4'h1, 4'hF};
      logic [7:0]  as  [4] = '{8'h7F, 8'h05, 8'h00, 8'h12};
      logic [7:0]  bs  [4] = '{8'h01, 8'h05, 8'h01, 8'h34};
      logic [12:0] exp [4] = '{{8'h80, 5'b00110}, {8'h00, 5'b11000},
                               {8'hFF, 5'b00010}, {8'h00, 5'b01001}};
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], obs, lat);
         total++;
         if (obs !== exp[i] || lat != 1) begin
            bad++;
            $display("FAIL directed_%0d: got %h lat %0d want %h lat 1", i, obs, lat, exp[i]);
         end
      end
   endtask

   task automatic test_mul();
      @(negedge clk);
      in_valid = 1'b1; op = 4'h2; a = 8'h3F; b = 8'hAF; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 4'h0;
      for (int k = 1; k <= 4; k++) begin
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL mul_busy_%0d: in_ready %b out_valid %b want 0 0", k, in_ready, out_valid);
         end
         @(negedge clk);
      end
      total++;
      if ({out_valid, result, carry, zero, overflow, sign, err} !== {1'b1, 8'hE1, 5'b00010}) begin
         bad++;
         $display("FAIL mul_result: got %h want %h", {out_valid, result, carry, zero, overflow, sign, err},
                  {1'b1, 8'hE1, 5'b00010});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] xa, ya;
      logic [12:0] exp;
      @(negedge clk);
      in_valid = 1'b1; op = 4'h5; a = 8'h81; b = 8'h00; out_ready = 1'b0;
      @(negedge clk);
      xa = 8'($urandom); ya = 8'($urandom);
      op = 4'h0; a = xa; b = ya;
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({out_valid, in_ready, result, carry} !== {1'b1, 1'b0, 8'h40, 1'b1}) begin
            bad++;
            $display("FAIL hold_%0d: got %h want %h", k, {out_valid, in_ready, result, carry},
                     {1'b1, 1'b0, 8'h40, 1'b1});
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp = model(4'h0, xa, ya);
         @(negedge clk);
         total++;
         if ({out_valid, result, carry, zero, overflow, sign, err} !== {1'b1, exp}) begin
            bad++;
            $display("FAIL b2b_add_%0d: got %h want %h", i, {out_valid, result, carry, zero, overflow, sign, err},
                     {1'b1, exp});
         end
         xa = 8'($urandom); ya = 8'($urandom);
         a = xa; b = ya;
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [3:0]  legal [10] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC};
      logic [3:0]  o;
      logic [7:0]  xa, ya;
      logic [12:0] obs, exp;
      int          lat, exp_lat;
      for (int i = 0; i < 150; i++) begin
         o  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal[$urandom_range(0, 9)];
         xa = 8'($urandom);
         ya = 8'($urandom);
         exp     = model(o, xa, ya);
         exp_lat = (o == 4'h2) ? 5 : 1;
         run_op(o, xa, ya, obs, lat);
         total++;
         if (obs !== exp || lat != exp_lat) begin
            bad++;
            $display("FAIL random_%0d op %h a %h b %h: got %h lat %0d want %h lat %0d",
                     i, o, xa, ya, obs, lat, exp, exp_lat);
         end
      end
   endtask

   task automatic test_reset_mid_mul();
      logic [12:0] obs;
      int          lat;
      @(negedge clk);
      in_valid = 1'b1; op = 4'h2; a = 8'h0F; b = 8'h0F; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, result, carry, zero, overflow, sign, err} !== 14'h0) begin
         bad++;
         $display("FAIL rst_mid_mul: got %h want 0", {out_valid, result, carry, zero, overflow, sign, err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0 || result !== 8'h00) begin
            bad++; $display("FAIL stale_%0d: out_valid %b result %h want 0 00", k, out_valid, result);
         end
      end
      run_op(4'h2, 8'h37, 8'h2B, obs, lat);
      total++;
      if (obs !== model(4'h2, 8'h37, 8'h2B) || lat != 5) begin
         bad++;
         $display("FAIL post_reset_mul: got %h lat %0d want %h lat 5", obs, lat, model(4'h2, 8'h37, 8'h2B));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mul();
      test_back_to_back();
      test_random();
      test_reset_mid_mul();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
